// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W           = 16;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned DEF_STARVE_LIMIT = 8;
    localparam int unsigned DEF_CW           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_I = 2'd1,
        ST_OWN_D = 2'd2,
        ST_WRITE = 2'd3
    } arb_state_t;

    // Command presented on the memory port
    typedef struct packed {
        logic              en;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_age_counter.sv
// Saturating wait counter that tracks how long the I-cache has been losing arbitration.
module mem_arb_age_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CW-1:0] LIMIT_CW = CW'(LIMIT);

    logic [CW-1:0] count;

    // Clear wins over increment; holds once the limit is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CW'(1);
        end
    end

    assign sat = (count == LIMIT_CW);

endmodule

// File: rtl/mem_arbiter.sv
// Single-owner arbiter for the main-memory port: D-side fill, I-side fill and
// write-through stores, fixed priority D over I with an I-cache starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned CW           = DEF_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mem_data_valid,
    output logic              ic_grant,
    output logic              dc_grant,
    output logic              wr_ack,
    output logic              ic_data_vld,
    output logic              dc_data_vld,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       age_sat;
    logic       age_inc;
    logic       age_clr;
    mem_cmd_t   mem_cmd;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: an IDLE cycle always separates two ownerships
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (age_sat && ic_req) begin
                    state_d = ST_OWN_I;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                end else if (dc_req) begin
                    state_d = ST_OWN_D;
                end else if (ic_req) begin
                    state_d = ST_OWN_I;
                end
            end
            ST_OWN_I: begin
                if (!ic_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN_D: begin
                if (!dc_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign age_inc = ic_req && (state_q != ST_OWN_I);
    assign age_clr = !ic_req || (state_d == ST_OWN_I);

    mem_arb_age_counter #(
        .CW    (CW),
        .LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk (clk),
        .rst (rst),
        .inc (age_inc),
        .clr (age_clr),
        .sat (age_sat)
    );

    // Output decode from the registered state; memory port is quiet in IDLE
    always_comb begin
        ic_grant    = 1'b0;
        dc_grant    = 1'b0;
        wr_ack      = 1'b0;
        mem_cmd     = '0;
        unique case (state_q)
            ST_OWN_I: begin
                ic_grant     = 1'b1;
                mem_cmd.en   = 1'b1;
                mem_cmd.addr = ic_addr;
            end
            ST_OWN_D: begin
                dc_grant     = 1'b1;
                mem_cmd.en   = 1'b1;
                mem_cmd.addr = dc_addr;
            end
            ST_WRITE: begin
                wr_ack       = 1'b1;
                mem_cmd.en   = 1'b1;
                mem_cmd.wr   = 1'b1;
                mem_cmd.addr = wr_addr;
                mem_cmd.data = wr_data;
            end
            default: begin
                mem_cmd = '0;
            end
        endcase
    end

    assign mem_en      = mem_cmd.en;
    assign mem_wr      = mem_cmd.wr;
    assign mem_addr    = mem_cmd.addr;
    assign mem_data_in = mem_cmd.data;

    // Read data is only ever steered to the current owner
    assign ic_data_vld = mem_data_valid && ic_grant;
    assign dc_data_vld = mem_data_valid && dc_grant;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-owner arbiter sharing the one main-memory port between three requesters:
  - I-cache fill FSM
  - D-cache fill FSM
  - D-cache write-through store path
- Sits between both caches and the multi-cycle pipelined memory.
- Grants ownership and routes the selected requester's address/data to memory.
- Steers returning data-valid to the owner only and holds the other requesters stalled.
- Fixed priority D over I, with an age counter that guarantees I-cache forward progress.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles the I-cache may wait while losing arbitration before it is promoted above D-side requests.
- CW, 4: width of the age counter; must satisfy 2^CW > STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ic_req  in  1  I-cache fill FSM busy; held high for the whole fill
- ic_addr  in  16  I-cache fill memory address
- dc_req  in  1  D-cache fill FSM busy; held high for the whole fill
- dc_addr  in  16  D-cache fill memory address
- wr_req  in  1  D-cache write-through request; held until wr_ack
- wr_addr  in  16  store address
- wr_data  in  16  store data
- mem_data_valid  in  1  memory read-data valid
- ic_grant  out  1  I-cache owns memory
- dc_grant  out  1  D-cache fill owns memory
- wr_ack  out  1  one-cycle store-accepted pulse
- ic_data_vld  out  1  mem_data_valid gated by ic_grant
- dc_data_vld  out  1  mem_data_valid gated by dc_grant
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_data_in  out  16  memory write data

Behaviour:
- State register (2 bits):
  - IDLE = 0
  - OWN_I = 1
  - OWN_D = 2
  - WRITE = 3
- Reset:
  - State returns to IDLE and age clears to 0.
  - All outputs read 0: grants, wr_ack, data_vld, mem_en, mem_wr, mem_addr, mem_data_in.
- IDLE selection, in priority order; the chosen state is registered:
  - If age == STARVE_LIMIT and ic_req: go to OWN_I.
  - Else if wr_req: go to WRITE.
  - Else if dc_req: go to OWN_D.
  - Else if ic_req: go to OWN_I.
  - Else stay in IDLE.
- Grant latency: a request first sampled high in cycle N is granted in cycle N+1 at the earliest.
- OWN_I / OWN_D:
  - Grant held while the owner's req stays high.
  - mem_en = 1, mem_wr = 0, mem_addr = owner's address.
  - When owner req is sampled low, next state is IDLE.
  - Fill FSMs keep req high through memory latency, so no read is in flight at release.
- WRITE:
  - Lasts exactly 1 cycle: mem_en = 1, mem_wr = 1, mem_addr = wr_addr, mem_data_in = wr_data, wr_ack = 1.
  - Next state is IDLE.
- There is always one IDLE cycle between owners; back-to-back grants to different requesters are not allowed.
- Age counter:
  - Increments when ic_req = 1 and the state is not OWN_I, saturating at STARVE_LIMIT.
  - Clears on entry to OWN_I and whenever ic_req = 0.
- Outputs are decoded combinationally from the registered state; mem_* are 0 in IDLE.
- data_vld steering: mem_data_valid while in IDLE or WRITE is dropped. It must not occur there; the bench flags it as an error.
- Simultaneous wr_req and dc_req:
  - Store goes first.
  - The fill is granted after the intervening IDLE cycle, with age permitting.
- Owner's req drops in the same cycle another request rises: the new request is arbitrated in the following IDLE cycle.
- Reset asserted mid-ownership: immediate return to IDLE with all outputs 0, independent of clk.

Decomposition:
- Shared package:
  - Arbiter state encodings (IDLE/OWN_I/OWN_D/WRITE).
  - STARVE_LIMIT default.
  - Memory address width constant (16).
- One sub-module: mem_arb_age_counter.
  - Saturating CW-bit counter with increment, clear and saturate-flag outputs.
  - Asynchronous active-high reset.

Test Plan:
- Lone I-fill: ic_req=1 at cycle 2, ic_addr=0x1230.
  - Required: ic_grant=1 from cycle 3, mem_en=1, mem_addr=0x1230.
  - Drop ic_req at cycle 14: ic_grant=0 at cycle 15, state IDLE.
- Store vs fill collision: wr_req=1 (wr_addr=0x00A0, wr_data=0xBEEF) and dc_req=1 in the same cycle N.
  - Required: cycle N+1 has mem_wr=1, mem_addr=0x00A0, mem_data_in=0xBEEF, wr_ack=1.
  - Cycle N+2 is IDLE; dc_grant=1 at N+3.
- Steering: under OWN_D, pulse mem_data_valid 8 times.
  - Required: dc_data_vld pulses 8 times; ic_data_vld stays 0 even with ic_req=1.
- Starvation: hold ic_req=1 while dc_req/wr_req keep winning for 8 waiting cycles.
  - Required: at the next IDLE, ic_grant wins over a simultaneous dc_req, and age reads 0 after entry to OWN_I.
- Reset mid-fill: assert rst asynchronously between edges while in OWN_D.
  - Required: dc_grant, mem_en and mem_addr read 0 before the next clk edge.
  - After release with no requests, state stays IDLE.
- Idle quiescence: no requests for 20 cycles.
  - Required: mem_en=0, all grants 0, wr_ack never pulses.
